mand_frame_driver: RTL
======================

Name: mand_frame_driver

Overview:
- Initiator for one mand_solver instance.
- Walks a WIDTH x HEIGHT pixel grid in raster order and computes each pixel's complex coordinate c in 7.20 fixed point.
- For each pixel: loads the solver, waits for its out_ready, then presents the iteration count on a valid/ready pixel stream toward the colour-map / frame-buffer writer.

Parameters:
- WIDTH, 640, pixels per row (>=1).
- HEIGHT, 480, rows per frame (>=1).
- CW, 27, fixed-point coordinate width; FRAC=20 fractional bits (package constant).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- re_origin  in  27  signed c_re of pixel (0,0); sampled on accepted start.
- im_origin  in  27  signed c_im of pixel (0,0); sampled on accepted start.
- step  in  27  signed per-pixel increment; sampled on accepted start.
- busy  out  1  high from accepted start until frame done.
- frame_done  out  1  one-cycle pulse after last pixel is accepted.
- solver_reset  out  1  synchronous active-high load strobe to mand_solver.reset.
- solver_c_re  out  27  to mand_solver.c_re.
- solver_c_im  out  27  to mand_solver.c_im.
- solver_ready  in  1  from mand_solver.out_ready.
- solver_out  in  32  from mand_solver.out; -1 means converged.
- pix_valid  out  1  result valid.
- pix_ready  in  1  downstream accept.
- pix_x  out  10  pixel column.
- pix_y  out  9  pixel row.
- pix_iter  out  32  iteration count, or -1.

Behaviour:
- Reset values:
  - busy=0, frame_done=0, pix_valid=0, pix_x=0, pix_y=0, pix_iter=0, solver_c_re=0, solver_c_im=0.
  - solver_reset=1, which holds the solver idle.
  - Internal counters 0; state IDLE.
- States: IDLE, LOAD, ARM, WAIT, EMIT, DONE.
- IDLE:
  - solver_reset=1.
  - start=1: latch origin/step, set c_re=re_origin, c_im=im_origin, x=y=0, busy=1, go to LOAD.
  - start is ignored in every other state.
- LOAD (1 cycle): solver_reset=1 with solver_c_re/solver_c_im already stable at the new pixel's c; go to ARM.
- ARM (1 cycle):
  - solver_reset=0.
  - The solver's out_ready is still its reset value 0, so solver_ready is ignored here; go to WAIT.
- WAIT:
  - solver_reset=0. solver_c_re/solver_c_im must stay constant, because the solver reads c every iteration.
  - When solver_ready=1: capture solver_out into pix_iter, x/y into pix_x/pix_y, set pix_valid=1, go to EMIT.
- EMIT:
  - pix_valid, pix_x, pix_y and pix_iter stay stable until pix_ready=1.
  - The solver is not reloaded while in EMIT. Its outputs hold because it stops iterating once out_ready=1.
  - On handshake: pix_valid=0 next cycle, then advance the pixel.
  - Not last column: x+1, c_re+=step, go to LOAD.
  - Last column, not last row: x=0, y+1, c_re=re_origin, c_im-=step (imaginary axis points up the screen), go to LOAD.
  - Last pixel: go to DONE.
- DONE (1 cycle): frame_done=1, busy=0, solver_reset=1, go to IDLE.
- Arithmetic:
  - c accumulation is CW-bit two's complement and wraps silently; no saturation.
  - Origin and step are never re-sampled mid-frame.
- Minimum per-pixel latency is LOAD + ARM + solver cycles + EMIT. If pix_ready is held high, consecutive pixels are separated by >=4 cycles.
- Reset mid-frame: immediate return to IDLE with all reset values; the in-flight pixel is discarded and no frame_done is issued.
- WIDTH=1 or HEIGHT=1 are legal. A 1x1 frame emits exactly one pixel, then frame_done.

Optional Feature:
- Macro: MAND_FRAME_DRIVER_STATS_EN.
- When defined:
  - Adds output conv_count [31:0]: count of pixels emitted with pix_iter == -1 in the current frame.
  - Adds output frame_cycles [31:0]: cycles from accepted start to frame_done inclusive.
  - Both clear on accepted start, hold after DONE, and reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package mand_pkg:
  - FIX_W=27, FIX_FRAC=20.
  - ITER_CONVERGED=-32'd1.
  - Fixed-point literal helper constants ONE=1<<20, TWO=2<<20.
  - State encoding for the driver FSM.
- Sub-module mand_coord_gen:
  - Holds x/y counters and the c_re/c_im accumulators.
  - Provides load/advance controls and a last_col/last_pix flag; the FSM stays in mand_frame_driver.

Test Plan:
- Sweep: WIDTH=4, HEIGHT=2, re_origin=-2.0 (-2<<20), im_origin=0.5 (0x80000), step=0.5, real mand_solver attached, pix_ready=1 -> c_re sequence -2.0,-1.5,-1.0,-0.5 per row; c_im 0.5 then 0.0; 8 pixels in raster order; one frame_done.
- Convergence: pixel at c=0+0j -> pix_iter=-1. Pixel at c=1.0+0j -> small positive count equal to an independent reference model of mand_solver.
- Backpressure: hold pix_ready=0 for 10 cycles during EMIT -> pix_valid stays 1, pix_x/pix_y/pix_iter unchanged, solver_reset stays 0, no extra pixels.
- Start while busy: pulse start with different origin mid-frame -> ignored; coordinates continue from the original latch.
- Mid-frame reset: assert reset low during WAIT of pixel 3 -> outputs reach reset values asynchronously and solver_reset=1; new start restarts at (0,0) with no frame_done from the aborted frame.
- 1x1 frame with stats enabled, c=0 -> exactly one pixel with pix_iter=-1; conv_count=1; frame_done after handshake.

Source files
------------

// File: rtl/mand_pkg.sv
// Shared constants, fixed-point helpers and driver FSM encoding for the Mandelbrot
// frame driver and its coordinate generator.
package mand_pkg;

    localparam int FIX_W    = 27;
    localparam int FIX_FRAC = 20;

    localparam logic [31:0] ITER_CONVERGED = -32'sd1;

    localparam logic signed [FIX_W-1:0] ONE = FIX_W'(1 << FIX_FRAC);
    localparam logic signed [FIX_W-1:0] TWO = FIX_W'(2 << FIX_FRAC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } drv_state_t;

    function automatic logic is_converged(input logic [31:0] iter);
        return iter == ITER_CONVERGED;
    endfunction

endpackage

// File: rtl/mand_coord_gen.sv
// Raster pixel counters and complex-coordinate accumulators for one frame.
// Origin and step are latched on init and never re-sampled mid-frame.
module mand_coord_gen
    import mand_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = FIX_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 advance,
    input  logic signed [CW-1:0] re_origin,
    input  logic signed [CW-1:0] im_origin,
    input  logic signed [CW-1:0] step,
    output logic [9:0]           x,
    output logic [8:0]           y,
    output logic signed [CW-1:0] c_re,
    output logic signed [CW-1:0] c_im,
    output logic                 last_pix
);

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    logic signed [CW-1:0] re_org_q;
    logic signed [CW-1:0] step_q;
    logic                 last_col;

    assign last_col = (x == X_LAST);
    assign last_pix = last_col && (y == Y_LAST);

    // Accumulation wraps silently in CW-bit two's complement; imaginary axis points up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            re_org_q <= '0;
            step_q   <= '0;
            x        <= '0;
            y        <= '0;
            c_re     <= '0;
            c_im     <= '0;
        end else if (init) begin
            re_org_q <= re_origin;
            step_q   <= step;
            x        <= '0;
            y        <= '0;
            c_re     <= re_origin;
            c_im     <= im_origin;
        end else if (advance) begin
            if (last_col) begin
                x    <= '0;
                y    <= y + 9'd1;
                c_re <= re_org_q;
                c_im <= c_im - step_q;
            end else begin
                x    <= x + 10'd1;
                c_re <= c_re + step_q;
            end
        end
    end

endmodule

// File: rtl/mand_frame_driver.sv
// Drives one mand_solver across a WIDTH x HEIGHT frame and streams iteration counts.
// Optional per-frame statistics ports are enabled by MAND_FRAME_DRIVER_STATS_EN.
module mand_frame_driver
    import mand_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = FIX_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [CW-1:0] re_origin,
    input  logic signed [CW-1:0] im_origin,
    input  logic signed [CW-1:0] step,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 solver_reset,
    output logic signed [CW-1:0] solver_c_re,
    output logic signed [CW-1:0] solver_c_im,
    input  logic                 solver_ready,
    input  logic [31:0]          solver_out,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [9:0]           pix_x,
    output logic [8:0]           pix_y,
    output logic [31:0]          pix_iter
`ifdef MAND_FRAME_DRIVER_STATS_EN
    ,
    output logic [31:0]          conv_count,
    output logic [31:0]          frame_cycles
`endif
);

    drv_state_t state;
    logic       init;
    logic       advance;
    logic       handshake;
    logic [9:0] cur_x;
    logic [8:0] cur_y;
    logic       last_pix;

    always_comb begin
        init      = (state == ST_IDLE) && start;
        handshake = (state == ST_EMIT) && pix_ready;
        advance   = handshake && !last_pix;
    end

    mand_coord_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .CW     (CW)
    ) u_coord (
        .clock     (clock),
        .reset     (reset),
        .init      (init),
        .advance   (advance),
        .re_origin (re_origin),
        .im_origin (im_origin),
        .step      (step),
        .x         (cur_x),
        .y         (cur_y),
        .c_re      (solver_c_re),
        .c_im      (solver_c_im),
        .last_pix  (last_pix)
    );

    // solver_reset is registered: dropping it while in LOAD makes it low throughout ARM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            solver_reset <= 1'b1;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_iter     <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    solver_reset <= 1'b1;
                    if (start) begin
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    solver_reset <= 1'b0;
                    state        <= ST_ARM;
                end
                ST_ARM: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (solver_ready) begin
                        pix_iter  <= solver_out;
                        pix_x     <= cur_x;
                        pix_y     <= cur_y;
                        pix_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (pix_ready) begin
                        pix_valid    <= 1'b0;
                        solver_reset <= 1'b1;
                        if (last_pix) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MAND_FRAME_DRIVER_STATS_EN
    // The start cycle counts as 1; the final value settles on the edge closing DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conv_count   <= '0;
            frame_cycles <= '0;
        end else if (init) begin
            conv_count   <= '0;
            frame_cycles <= 32'd1;
        end else begin
            if (state != ST_IDLE) begin
                frame_cycles <= frame_cycles + 32'd1;
            end
            if (handshake && is_converged(pix_iter)) begin
                conv_count <= conv_count + 32'd1;
            end
        end
    end
`endif

endmodule
